// File: rtl/float32_pkg.sv
// Shared float32 field widths, constants and enums for the divider datapath.
// The operand classifier lives here so the multiplier can reuse it.
package float32_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;

    localparam int unsigned  EXP_BIAS     = 127;
    localparam logic [7:0]   EXP_MAX      = 8'hFF;
    localparam logic [31:0]  FP32_QNAN    = 32'h7FC00000;
    localparam logic [30:0]  FP32_INF_MAG = 31'h7F800000;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_e;

    typedef enum logic [1:0] {SC_NONE, SC_NAN, SC_INF, SC_ZERO} sc_e;

    // Exponent 0 counts as zero, so input denormals are flushed.
    function automatic sc_e classify_div(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        sc_e  sc;
        a_nan  = (a[30:23] == EXP_MAX) && (a[22:0] != '0);
        b_nan  = (b[30:23] == EXP_MAX) && (b[22:0] != '0);
        a_inf  = (a[30:23] == EXP_MAX) && (a[22:0] == '0);
        b_inf  = (b[30:23] == EXP_MAX) && (b[22:0] == '0);
        a_zero = (a[30:23] == '0);
        b_zero = (b[30:23] == '0);
        if (a_nan || b_nan) begin
            sc = SC_NAN;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            sc = SC_NAN;
        end else if (a_inf || b_zero) begin
            sc = SC_INF;
        end else if (b_inf || a_zero) begin
            sc = SC_ZERO;
        end else begin
            sc = SC_NONE;
        end
        return sc;
    endfunction

endpackage

// File: rtl/float32_round_pack.sv
// Normalise a 26-bit quotient, round to nearest even, clamp and pack to float32.
// Purely combinational; special-case code overrides the computed value.
module float32_round_pack
    import float32_pkg::*;
(
    input  logic              sign_i,
    input  logic [25:0]       q_i,
    input  logic              rem_nz_i,
    input  logic signed [9:0] exp_diff_i,
    input  sc_e               sc_i,
    output logic [31:0]       result_o
);

    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic [23:0]       mant_inc;
    logic signed [9:0] exp_v;

    always_comb begin
        mant     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        exp_v    = '0;
        mant_inc = '0;
        result_o = '0;

        if (q_i[25]) begin
            mant   = q_i[24:2];
            guard  = q_i[1];
            sticky = q_i[0] | rem_nz_i;
            exp_v  = exp_diff_i + $signed(10'(EXP_BIAS));
        end else begin
            mant   = q_i[23:1];
            guard  = q_i[0];
            sticky = rem_nz_i;
            exp_v  = exp_diff_i + $signed(10'(EXP_BIAS - 1));
        end

        mant_inc = {1'b0, mant} + {23'b0, guard & (sticky | mant[0])};
        // A carry out means the mantissa wrapped to zero and the value doubled.
        if (mant_inc[23]) begin
            exp_v = exp_v + 10'sd1;
        end
        mant = mant_inc[22:0];

        unique case (sc_i)
            SC_NAN:  result_o = FP32_QNAN;
            SC_INF:  result_o = {sign_i, FP32_INF_MAG};
            SC_ZERO: result_o = {sign_i, 31'b0};
            default: begin
                if (exp_v >= 10'sd255) begin
                    result_o = {sign_i, FP32_INF_MAG};
                end else if (exp_v <= 10'sd0) begin
                    result_o = {sign_i, 31'b0};
                end else begin
                    result_o = {sign_i, exp_v[7:0], mant};
                end
            end
        endcase
    end

endmodule

// File: rtl/float32_divide.sv
// Iterative float32 divider: restoring division, fixed latency, valid/ready on both sides.
// One operation in flight; the DIV phase always runs its full length, even for specials.
module float32_divide
    import float32_pkg::*;
#(
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic        in_clk,
    input  logic        in_rstn,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_result,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned N_ITER = 26 / ITER_PER_CYCLE;

    state_e            state_q, state_d;
    logic [4:0]        count_q, count_d;
    logic              sign_q, sign_d;
    logic [23:0]       mb_q, mb_d;
    logic [24:0]       rem_q, rem_d;
    logic [25:0]       quo_q, quo_d;
    logic signed [9:0] exp_diff_q, exp_diff_d;
    sc_e               sc_q, sc_d;
    logic [31:0]       result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [31:0] packed_result;
    logic [24:0] r_step;
    logic [25:0] q_step;
    logic [25:0] diff;

    float32_round_pack u_round_pack (
        .sign_i     (sign_q),
        .q_i        (quo_q),
        .rem_nz_i   (rem_q != '0),
        .exp_diff_i (exp_diff_q),
        .sc_i       (sc_q),
        .result_o   (packed_result)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sign_d      = sign_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        exp_diff_d  = exp_diff_q;
        sc_d        = sc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        r_step      = rem_q;
        q_step      = quo_q;
        diff        = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d     = in_A[31] ^ in_B[31];
                    rem_d      = {2'b01, in_A[22:0]};
                    mb_d       = {1'b1, in_B[22:0]};
                    quo_d      = '0;
                    exp_diff_d = $signed({2'b00, in_A[30:23]}) - $signed({2'b00, in_B[30:23]});
                    sc_d       = classify_div(in_A, in_B);
                    count_d    = 5'(N_ITER);
                    state_d    = DIV;
                end
            end
            DIV: begin
                if (count_q == '0) begin
                    state_d = NORM;
                end else begin
                    // Remainder stays below 2*mB, so 25 bits hold it after each shift.
                    for (int i = 0; i < int'(ITER_PER_CYCLE); i++) begin
                        diff = {1'b0, r_step} - {2'b00, mb_q};
                        if (!diff[25]) begin
                            r_step = diff[24:0];
                            q_step = {q_step[24:0], 1'b1};
                        end else begin
                            q_step = {q_step[24:0], 1'b0};
                        end
                        r_step = {r_step[23:0], 1'b0};
                    end
                    rem_d   = r_step;
                    quo_d   = q_step;
                    count_d = count_q - 5'd1;
                end
            end
            NORM: begin
                result_d    = packed_result;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sign_q      <= 1'b0;
            mb_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            exp_diff_q  <= '0;
            sc_q        <= SC_NONE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sign_q      <= sign_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            exp_diff_q  <= exp_diff_d;
            sc_q        <= sc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_result = result_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_float32_divide.sv
// Self-checking bench for float32_divide: one-bit and two-bit-per-cycle instances,
// expected results queued at stimulus time and popped when the result appears.
module tb_float32_divide;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [31:0] a1, b1, res1, a2, b2, res2;
    logic        iv1, ir1, ov1, or1, iv2, ir2, ov2, or2;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    float32_divide #(.ITER_PER_CYCLE(1)) dut (
        .in_clk     (clk),
        .in_rstn    (rstn),
        .in_A       (a1),
        .in_B       (b1),
        .in_valid   (iv1),
        .in_ready   (ir1),
        .out_result (res1),
        .out_valid  (ov1),
        .out_ready  (or1)
    );

    float32_divide #(.ITER_PER_CYCLE(2)) dut2 (
        .in_clk     (clk),
        .in_rstn    (rstn),
        .in_A       (a2),
        .in_B       (b2),
        .in_valid   (iv2),
        .in_ready   (ir2),
        .out_result (res2),
        .out_valid  (ov2),
        .out_ready  (or2)
    );

    // Drives one operation, returns the result and edges from accept to out_valid.
    task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit ok);
        int wait_cnt;
        ok = 1'b1;
        lat = 0;
        res = '0;
        wait_cnt = 0;
        if (sel) begin a2 = a; b2 = b; iv2 = 1'b1; end
        else     begin a1 = a; b1 = b; iv1 = 1'b1; end
        while (!(sel ? ir2 : ir1)) begin
            @(posedge clk); #1;
            wait_cnt++;
            if (wait_cnt > 100) begin ok = 1'b0; break; end
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        iv1 = 1'b0;
        iv2 = 1'b0;
        if (ok) begin
            while (!(sel ? ov2 : ov1)) begin
                @(posedge clk); #1;
                lat++;
                if (lat > 100) begin ok = 1'b0; break; end
            end
        end
        res = sel ? res2 : res1;
        if (ok && (sel ? or2 : or1)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_checks++;
        if (ir1 !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", ir1);
        else n_pass++;
        n_checks++;
        if (ov1 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov1);
        else n_pass++;
        n_checks++;
        if (res1 !== 32'h0) $display("FAIL reset_out_result: got %h expected 00000000", res1);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [31:0] ta[4] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h41200000};
        logic [31:0] tb[4] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40A00000};
        logic [31:0] te[4] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'h40000000};
        logic [31:0] res, want;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(te[i]);
            run_op(1'b0, ta[i], tb[i], res, lat, ok);
            want = exp_q.pop_front();
            n_checks++;
            if (!ok || res !== want)
                $display("FAIL arith_%0d: got %h (ok=%0d) expected %h", i, res, ok, want);
            else n_pass++;
            n_checks++;
            if (lat !== 28) $display("FAIL arith_latency_%0d: got %0d expected 28", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_iter2();
        logic [31:0] ta[2] = '{32'h40C00000, 32'h3F800000};
        logic [31:0] tb[2] = '{32'h40000000, 32'h40400000};
        logic [31:0] te[2] = '{32'h40400000, 32'h3EAAAAAB};
        logic [31:0] res, want;
        int lat;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(te[i]);
            run_op(1'b1, ta[i], tb[i], res, lat, ok);
            want = exp_q.pop_front();
            n_checks++;
            if (!ok || res !== want)
                $display("FAIL iter2_%0d: got %h (ok=%0d) expected %h", i, res, ok, want);
            else n_pass++;
            n_checks++;
            if (lat !== 15) $display("FAIL iter2_latency_%0d: got %0d expected 15", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_specials();
        logic [31:0] ta[8] = '{32'h3F800000, 32'h80000000, 32'hFF800000, 32'h40000000,
                               32'h7FC00001, 32'h7F000000, 32'h00800000, 32'h00400000};
        logic [31:0] tb[8] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'hFF800000,
                               32'h3F800000, 32'h3E800000, 32'h7F000000, 32'h3F800000};
        logic [31:0] te[8] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
                               32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000};
        logic [31:0] res, want;
        int lat;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(te[i]);
            run_op(1'b0, ta[i], tb[i], res, lat, ok);
            want = exp_q.pop_front();
            n_checks++;
            if (!ok || res !== want || lat !== 28)
                $display("FAIL special_%0d: got %h lat %0d (ok=%0d) expected %h lat 28",
                         i, res, lat, ok, want);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res, want;
        int lat;
        bit ok;
        or1 = 1'b0;
        exp_q.push_back(32'h40400000);
        run_op(1'b0, 32'h40C00000, 32'h40000000, res, lat, ok);
        want = exp_q.pop_front();
        n_checks++;
        if (!ok || res !== want) $display("FAIL bp_result: got %h expected %h", res, want);
        else n_pass++;
        a1 = 32'h41200000;
        b1 = 32'h40A00000;
        iv1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ov1 !== 1'b1 || res1 !== want || ir1 !== 1'b0)
                $display("FAIL bp_hold_%0d: got valid=%b result=%h in_ready=%b expected 1 %h 0",
                         i, ov1, res1, ir1, want);
            else n_pass++;
        end
        iv1 = 1'b0;
        or1 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1)
            $display("FAIL bp_release: got valid=%b in_ready=%b expected 0 1", ov1, ir1);
        else n_pass++;
        // The ignored operand must not have started a divide.
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1)
            $display("FAIL bp_no_ghost: got valid=%b in_ready=%b expected 0 1", ov1, ir1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, want;
        int lat;
        bit ok;
        bit seen;
        a1 = 32'h41200000;
        b1 = 32'h40A00000;
        iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1)
            $display("FAIL midreset_async: got valid=%b in_ready=%b expected 0 1", ov1, ir1);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midreset_no_result: got valid seen=%b expected 0", seen);
        else n_pass++;
        exp_q.push_back(32'h40000000);
        run_op(1'b0, 32'h41200000, 32'h40A00000, res, lat, ok);
        want = exp_q.pop_front();
        n_checks++;
        if (!ok || res !== want || lat !== 28)
            $display("FAIL midreset_after: got %h lat %0d expected %h lat 28", res, lat, want);
        else n_pass++;
    endtask

    initial begin
        a1 = '0; b1 = '0; iv1 = 1'b0; or1 = 1'b1;
        a2 = '0; b2 = '0; iv2 = 1'b0; or2 = 1'b1;
        test_reset();
        test_arith();
        test_iter2();
        test_specials();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
